counter_seek_ctrl: RTL

- Control-side driver for the 5-bit up/down counter used by the datapath; it is the initiator that generates the counter's count-up, count-down and clear strobes.
- On a start request it steers the counter from its current value to a requested target value, one step at a time.
- After each step it checks the counter's returned value and zero flag against the value it expects.
- It reports completion or a mismatch error to the top-level controller through a start/done handshake.

---
 rtl/counter_pkg.sv | 36 +++
 rtl/counter_seek_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter seek controller: width, FSM states and
// the strobe encoding used to drive the 5-bit up/down counter.
package counter_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_CMP,
    ST_UP,
    ST_DN,
    ST_WAIT,
    ST_FIN,
    ST_FAIL
  } state_e;

  // Strobe bundle, bit order {rst5, cntD, cntU}; one-hot or all zero.
  typedef logic [2:0] strobe_t;

  localparam strobe_t STB_NONE = 3'b000;
  localparam strobe_t STB_UP   = 3'b001;
  localparam strobe_t STB_DN   = 3'b010;
  localparam strobe_t STB_CLR  = 3'b100;

  // Strobe pattern that goes with a state; only the stepping states drive one.
  function automatic strobe_t strobe_of(input state_e s);
    case (s)
      ST_UP:   return STB_UP;
      ST_DN:   return STB_DN;
      ST_CLR:  return STB_CLR;
      default: return STB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/counter_seek_ctrl.sv
// Seek controller: walks an external up/down counter from its current value
// to a requested target one step at a time, verifying the readback after
// each step, and reports done or err through a start/busy handshake.
module counter_seek_ctrl
  import counter_pkg::*;
#(
  parameter int W      = CNT_W,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         clear_req,
  input  logic [W-1:0] target,
  input  logic [W-1:0] cnt_val,
  input  logic         cnt_zero,
  output logic         cntU,
  output logic         cntD,
  output logic         rst5,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int SW = 2;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic [W-1:0]  exp_q, exp_d;
  logic [SW-1:0] settle_q, settle_d;
  strobe_t       strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          readback_bad;

  // Counter value or zero flag disagrees with what the last step should give.
  assign readback_bad = (cnt_val != exp_q) || (cnt_zero != (exp_q == '0));

  // Next-state, expected-value tracking and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    tgt_d    = tgt_q;
    exp_d    = exp_q;
    settle_d = settle_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tgt_d = target;
          if (clear_req) begin
            state_d = ST_CLR;
          end else begin
            exp_d   = cnt_val;
            state_d = ST_CMP;
          end
        end
      end
      ST_CLR: begin
        exp_d    = '0;
        settle_d = SETTLE_LAST;
        state_d  = ST_WAIT;
      end
      ST_CMP: begin
        // A bad readback wins over reaching the target, so done and err never coincide.
        if (readback_bad)         state_d = ST_FAIL;
        else if (exp_q == tgt_q)  state_d = ST_FIN;
        else if (exp_q < tgt_q)   state_d = ST_UP;
        else                      state_d = ST_DN;
      end
      ST_UP: begin
        exp_d    = exp_q + 1'b1;
        settle_d = SETTLE_LAST;
        state_d  = ST_WAIT;
      end
      ST_DN: begin
        exp_d    = exp_q - 1'b1;
        settle_d = SETTLE_LAST;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle_q == '0) state_d  = ST_CMP;
        else                settle_d = settle_q - 1'b1;
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered, then registered,
    // so they are glitch-free and line up with the state they belong to.
    strobe_d = strobe_of(state_d);
    busy_d   = !(state_d inside {ST_IDLE, ST_FIN, ST_FAIL});
    done_d   = (state_d == ST_FIN);
    err_d    = (state_d == ST_FAIL);
  end

  // State and output registers; reset aborts any seek with all strobes low.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the few control flops here are all reset; tgt/exp are reset too so
    // a post-reset request never compares against stale values.
    if (!rst) begin
      state_q  <= ST_IDLE;
      tgt_q    <= '0;
      exp_q    <= '0;
      settle_q <= '0;
      strobe_q <= STB_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      exp_q    <= exp_d;
      settle_q <= settle_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cntU = strobe_q[0];
  assign cntD = strobe_q[1];
  assign rst5 = strobe_q[2];
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
